// File: rtl/sbus_ctrl_pkg.sv
// Shared definitions for the slave-bus sequencer: FSM states, slave select codes
// and the default address-region codes decoded from adr[23:20].
package sbus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] SEL_RAM   = 3'd0;
   localparam logic [2:0] SEL_GPIA  = 3'd1;
   localparam logic [2:0] SEL_REMEX = 3'd2;
   localparam logic [2:0] SEL_ROM   = 3'd3;
   localparam logic [2:0] SEL_NONE  = 3'd4;

   localparam logic [3:0] REGION_RAM   = 4'h0;
   localparam logic [3:0] REGION_GPIA  = 4'h1;
   localparam logic [3:0] REGION_REMEX = 4'h2;
   localparam logic [3:0] REGION_ROM   = 4'hF;

   // SEL_NONE (bit 2 set) maps to no strobe at all.
   function automatic logic [3:0] sel_onehot(input logic [2:0] sel);
      logic [3:0] v;
      v = 4'b0000;
      if (!sel[2]) v[sel[1:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sbus_watchdog.sv
// Transfer watchdog: counts BUSY cycles and flags expiry on the cycle whose
// count equals TIMEOUT-1.
module sbus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= 8'd0;
      end else if (i_en) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/sbus_ctrl.sv
// Registered Wishbone slave-bus sequencer: decodes adr[23:20] to four slaves,
// auto-acks unmapped regions and terminates hung transfers via a watchdog.
module sbus_ctrl
   import sbus_ctrl_pkg::*;
#(
   parameter int         TIMEOUT   = 255,
   parameter logic [3:0] REG_RAM   = REGION_RAM,
   parameter logic [3:0] REG_GPIA  = REGION_GPIA,
   parameter logic [3:0] REG_REMEX = REGION_REMEX,
   parameter logic [3:0] REG_ROM   = REGION_ROM
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [23:0] m_adr_i,
   input  logic        m_cyc_i,
   input  logic        m_stb_i,
   input  logic        m_we_i,
   output logic        m_ack_o,
   output logic        m_err_o,
   output logic [15:0] m_dat_o,
   output logic [3:0]  s_stb_o,
   input  logic [3:0]  s_ack_i,
   input  logic [15:0] s_dat0_i,
   input  logic [15:0] s_dat1_i,
   input  logic [15:0] s_dat2_i,
   input  logic [15:0] s_dat3_i,
   output logic        fault_o,
   output logic [23:0] fault_adr_o,
   output logic        fault_we_o,
   input  logic        fault_clr_i
);

   state_t      r_state;
   logic [2:0]  r_sel;
   logic [23:0] r_adr;
   logic        r_we;
   logic        r_m_ack;
   logic        r_m_err;
   logic [15:0] r_m_dat;
   logic [3:0]  r_s_stb;
   logic        r_fault;
   logic [23:0] r_fault_adr;
   logic        r_fault_we;

   logic [2:0]  w_sel;
   logic [15:0] w_s_dat;
   logic        w_busy;
   logic        w_req;
   logic        w_expire;

   assign w_busy = (r_state == ST_BUSY);
   assign w_req  = m_cyc_i & m_stb_i;

   // First matching region wins if regions are configured to overlap.
   always_comb begin
      w_sel = SEL_NONE;
      if (m_adr_i[23:20] == REG_RAM)        w_sel = SEL_RAM;
      else if (m_adr_i[23:20] == REG_GPIA)  w_sel = SEL_GPIA;
      else if (m_adr_i[23:20] == REG_REMEX) w_sel = SEL_REMEX;
      else if (m_adr_i[23:20] == REG_ROM)   w_sel = SEL_ROM;
   end

   always_comb begin
      case (r_sel[1:0])
         2'd0:    w_s_dat = s_dat0_i;
         2'd1:    w_s_dat = s_dat1_i;
         2'd2:    w_s_dat = s_dat2_i;
         default: w_s_dat = s_dat3_i;
      endcase
   end

   sbus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .i_clk    (clk_i),
      .i_rst    (reset_i),
      .i_clr    (~w_busy),
      .i_en     (w_busy),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= ST_IDLE;
         r_sel       <= SEL_NONE;
         r_adr       <= 24'd0;
         r_we        <= 1'b0;
         r_m_ack     <= 1'b0;
         r_m_err     <= 1'b0;
         r_m_dat     <= 16'd0;
         r_s_stb     <= 4'b0000;
         r_fault     <= 1'b0;
         r_fault_adr <= 24'd0;
         r_fault_we  <= 1'b0;
      end else begin
         // A fault raised below in the same cycle overrides this clear.
         if (fault_clr_i) r_fault <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_m_ack <= 1'b0;
               r_m_err <= 1'b0;
               if (w_req) begin
                  r_sel   <= w_sel;
                  r_adr   <= m_adr_i;
                  r_we    <= m_we_i;
                  r_s_stb <= sel_onehot(w_sel);
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!w_req) begin
                  r_s_stb <= 4'b0000;
                  r_state <= ST_IDLE;
               end else if (r_sel == SEL_NONE) begin
                  r_m_dat <= 16'd0;
                  r_m_err <= 1'b0;
                  r_m_ack <= 1'b1;
                  r_state <= ST_DONE;
               end else if (s_ack_i[r_sel[1:0]]) begin
                  r_m_dat <= w_s_dat;
                  r_m_err <= 1'b0;
                  r_m_ack <= 1'b1;
                  r_s_stb <= 4'b0000;
                  r_state <= ST_DONE;
               end else if (w_expire) begin
                  r_m_dat     <= 16'd0;
                  r_m_err     <= 1'b1;
                  r_m_ack     <= 1'b1;
                  r_s_stb     <= 4'b0000;
                  r_fault     <= 1'b1;
                  r_fault_adr <= r_adr;
                  r_fault_we  <= r_we;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_m_ack <= 1'b0;
               r_m_err <= 1'b0;
               r_s_stb <= 4'b0000;
               r_state <= ST_IDLE;
            end
            default: begin
               r_m_ack <= 1'b0;
               r_m_err <= 1'b0;
               r_s_stb <= 4'b0000;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_ack_o     = r_m_ack;
   assign m_err_o     = r_m_err;
   assign m_dat_o     = r_m_dat;
   assign s_stb_o     = r_s_stb;
   assign fault_o     = r_fault;
   assign fault_adr_o = r_fault_adr;
   assign fault_we_o  = r_fault_we;

endmodule

// File: tb/tb_sbus_ctrl.sv
// Self-checking bench for sbus_ctrl: directed scenarios plus randomized
// transfers checked against a transaction-level reference model.
module tb_sbus_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [23:0] m_adr_i;
   logic        m_cyc_i;
   logic        m_stb_i;
   logic        m_we_i;
   logic        m_ack_o;
   logic        m_err_o;
   logic [15:0] m_dat_o;
   logic [3:0]  s_stb_o;
   logic [3:0]  s_ack_i;
   logic [15:0] s_dat0_i;
   logic [15:0] s_dat1_i;
   logic [15:0] s_dat2_i;
   logic [15:0] s_dat3_i;
   logic        fault_o;
   logic [23:0] fault_adr_o;
   logic        fault_we_o;
   logic        fault_clr_i;

   int checks   = 0;
   int failures = 0;

   logic        exp_fault;
   logic [23:0] exp_fadr;
   logic        exp_fwe;
   logic [15:0] sdat [4];

   sbus_ctrl #(.TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .m_adr_i     (m_adr_i),
      .m_cyc_i     (m_cyc_i),
      .m_stb_i     (m_stb_i),
      .m_we_i      (m_we_i),
      .m_ack_o     (m_ack_o),
      .m_err_o     (m_err_o),
      .m_dat_o     (m_dat_o),
      .s_stb_o     (s_stb_o),
      .s_ack_i     (s_ack_i),
      .s_dat0_i    (s_dat0_i),
      .s_dat1_i    (s_dat1_i),
      .s_dat2_i    (s_dat2_i),
      .s_dat3_i    (s_dat3_i),
      .fault_o     (fault_o),
      .fault_adr_o (fault_adr_o),
      .fault_we_o  (fault_we_o),
      .fault_clr_i (fault_clr_i)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // Slave index for an address, 4 = unmapped.
   function automatic int region_of(input logic [23:0] a);
      case (a[23:20])
         4'h0:    return 0;
         4'h1:    return 1;
         4'h2:    return 2;
         4'hF:    return 3;
         default: return 4;
      endcase
   endfunction

   // One transfer. d = strobed cycle (0-based) on which the slave acks;
   // pre = idle edges expected before the request is sampled;
   // hold = leave the request asserted for a chained transfer;
   // clr_edge = edge number at which fault_clr_i is sampled (0 = none).
   task automatic xfer(input logic [23:0] adr, input logic we, input int d,
                       input int pre, input bit hold, input int clr_edge);
      int          exp_sel, exp_lat, exp_str, lat, strobes;
      logic        exp_err, to, ack_now;
      logic [15:0] exp_dat;
      logic [3:0]  exp_oh, noise;
      s_dat0_i = sdat[0];
      s_dat1_i = sdat[1];
      s_dat2_i = sdat[2];
      s_dat3_i = sdat[3];
      exp_sel = region_of(adr);
      to = 1'b0;
      if (exp_sel == 4) begin
         exp_lat = 2; exp_str = 0; exp_err = 1'b0; exp_dat = 16'h0000;
      end else if (d <= TO - 1) begin
         exp_lat = d + 2; exp_str = d + 1; exp_err = 1'b0; exp_dat = sdat[exp_sel];
      end else begin
         exp_lat = TO + 1; exp_str = TO; exp_err = 1'b1; exp_dat = 16'h0000; to = 1'b1;
      end
      exp_lat = exp_lat + pre;
      exp_oh  = (exp_sel < 4) ? 4'(1 << exp_sel) : 4'b0000;
      m_adr_i = adr; m_we_i = we; m_cyc_i = 1'b1; m_stb_i = 1'b1;
      lat = -1; strobes = 0;
      for (int e = 1; e <= 40 && lat < 0; e++) begin
         ack_now = 1'b0;
         if (s_stb_o != 4'b0000) begin
            checks++;
            if (s_stb_o !== exp_oh) begin
               failures++;
               $display("FAIL stb_onehot adr=%h got=%b want=%b", adr, s_stb_o, exp_oh);
            end
            ack_now = (strobes == d);
            strobes++;
         end
         noise = 4'($urandom) & ~exp_oh;
         s_ack_i = noise | (ack_now ? exp_oh : 4'b0000);
         fault_clr_i = (e == clr_edge);
         @(posedge clk); @(negedge clk);
         fault_clr_i = 1'b0;
         if (m_ack_o) lat = e;
      end
      if (clr_edge >= 1 && clr_edge <= exp_lat) exp_fault = 1'b0;
      if (to) begin
         exp_fault = 1'b1; exp_fadr = adr; exp_fwe = we;
      end
      checks++;
      if (lat != exp_lat) begin
         failures++;
         $display("FAIL ack_latency adr=%h got=%0d want=%0d", adr, lat, exp_lat);
      end
      if (lat > 0) begin
         checks++;
         if (m_err_o !== exp_err) begin
            failures++;
            $display("FAIL err adr=%h got=%b want=%b", adr, m_err_o, exp_err);
         end
         checks++;
         if (m_dat_o !== exp_dat) begin
            failures++;
            $display("FAIL rdata adr=%h got=%h want=%h", adr, m_dat_o, exp_dat);
         end
         checks++;
         if (strobes != exp_str) begin
            failures++;
            $display("FAIL strobe_cycles adr=%h got=%0d want=%0d", adr, strobes, exp_str);
         end
         checks++;
         if (fault_o !== exp_fault || fault_adr_o !== exp_fadr || fault_we_o !== exp_fwe) begin
            failures++;
            $display("FAIL fault_state adr=%h got=%b/%h/%b want=%b/%h/%b", adr,
                     fault_o, fault_adr_o, fault_we_o, exp_fault, exp_fadr, exp_fwe);
         end
      end
      if (!hold) begin
         m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 4'b0000;
         @(posedge clk); @(negedge clk);
         checks++;
         if (m_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
            failures++;
            $display("FAIL ack_pulse adr=%h ack=%b stb=%b want 0/0000", adr, m_ack_o, s_stb_o);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || m_dat_o !== 16'h0 || s_stb_o !== 4'h0 ||
          fault_o !== 1'b0 || fault_adr_o !== 24'h0 || fault_we_o !== 1'b0) begin
         failures++;
         $display("FAIL %s ack=%b err=%b dat=%h stb=%b fault=%b fadr=%h fwe=%b want all zero",
                  name, m_ack_o, m_err_o, m_dat_o, s_stb_o, fault_o, fault_adr_o, fault_we_o);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_values");
      reset_i = 1'b0;
      exp_fault = 1'b0; exp_fadr = 24'h0; exp_fwe = 1'b0;
      @(posedge clk); @(negedge clk);
      check_all_zero("after_reset_idle");
   endtask

   task automatic test_ram_read();
      sdat[0] = 16'hBEEF; sdat[1] = 16'h1111; sdat[2] = 16'h2222; sdat[3] = 16'h3333;
      xfer(24'h000010, 1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_unmapped();
      xfer(24'h500000, 1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic test_timeout();
      xfer(24'h100002, 1'b1, 99, 0, 1'b0, 0);
   endtask

   task automatic test_ack_at_expiry();
      sdat[3] = 16'hC0DE;
      xfer(24'hF00040, 1'b0, TO - 1, 0, 1'b0, 0);
   endtask

   task automatic test_clr_collision();
      xfer(24'h200004, 1'b0, 99, 0, 1'b0, TO + 1);
   endtask

   task automatic test_fault_clr();
      fault_clr_i = 1'b1;
      @(posedge clk); @(negedge clk);
      fault_clr_i = 1'b0;
      exp_fault = 1'b0;
      checks++;
      if (fault_o !== 1'b0 || fault_adr_o !== exp_fadr) begin
         failures++;
         $display("FAIL fault_clr fault=%b fadr=%h want 0/%h", fault_o, fault_adr_o, exp_fadr);
      end
   endtask

   task automatic test_abort();
      m_adr_i = 24'h000020; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = 4'b0000;
      @(posedge clk); @(negedge clk);
      checks++;
      if (s_stb_o !== 4'b0001) begin
         failures++;
         $display("FAIL abort_stb_busy got=%b want=0001", s_stb_o);
      end
      @(posedge clk); @(negedge clk);
      m_stb_i = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (s_stb_o !== 4'b0000) begin
         failures++;
         $display("FAIL abort_stb_drop got=%b want=0000", s_stb_o);
      end
      m_cyc_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (m_ack_o !== 1'b0 || fault_o !== exp_fault) begin
            failures++;
            $display("FAIL abort_no_ack cyc=%0d ack=%b fault=%b want 0/%b", i, m_ack_o, fault_o, exp_fault);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_reset_busy();
      xfer(24'h2000AA, 1'b1, 99, 0, 1'b0, 0);
      m_adr_i = 24'h100008; m_we_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = 4'b0000;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (s_stb_o !== 4'b0010) begin
         failures++;
         $display("FAIL reset_busy_stb got=%b want=0010", s_stb_o);
      end
      reset_i = 1'b1;
      @(posedge clk); @(negedge clk);
      check_all_zero("reset_mid_busy");
      reset_i = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
      exp_fault = 1'b0; exp_fadr = 24'h0; exp_fwe = 1'b0;
      @(posedge clk); @(negedge clk);
      check_all_zero("reset_busy_release");
   endtask

   task automatic test_back_to_back();
      sdat[3] = 16'h5A5A;
      xfer(24'hF00000, 1'b0, 0, 0, 1'b1, 0);
      sdat[3] = 16'hA5A5;
      xfer(24'hF00002, 1'b0, 0, 1, 1'b0, 0);
   endtask

   task automatic test_random();
      logic [3:0] reg4;
      int         pick;
      for (int n = 0; n < 24; n++) begin
         pick = $urandom_range(0, 4);
         case (pick)
            0:       reg4 = 4'h0;
            1:       reg4 = 4'h1;
            2:       reg4 = 4'h2;
            3:       reg4 = 4'hF;
            default: reg4 = 4'($urandom_range(3, 14));
         endcase
         for (int i = 0; i < 4; i++) sdat[i] = 16'($urandom);
         xfer({reg4, 20'($urandom)}, 1'($urandom), $urandom_range(0, TO + 2), 0, 1'b0,
              $urandom_range(0, 2));
      end
   endtask

   initial begin
      reset_i = 1'b1; m_adr_i = 24'h0; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
      s_ack_i = 4'b0000; fault_clr_i = 1'b0;
      s_dat0_i = 16'h0; s_dat1_i = 16'h0; s_dat2_i = 16'h0; s_dat3_i = 16'h0;
      for (int i = 0; i < 4; i++) sdat[i] = 16'h0;
      exp_fault = 1'b0; exp_fadr = 24'h0; exp_fwe = 1'b0;
      @(negedge clk);
      test_reset();
      test_ram_read();
      test_unmapped();
      test_timeout();
      test_ack_at_expiry();
      test_clr_collision();
      test_fault_clr();
      test_abort();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
